// File: rtl/p_shfrot_pkg.sv
// Shared definitions for the packed shift/rotate issue stage: pack-width and
// op encodings, the decoded-request struct and a lane-mask helper.
package p_shfrot_pkg;

   // Pack-width encodings as they arrive on req_pw; 5..7 are illegal.
   localparam logic [2:0] PW_32 = 3'd0;
   localparam logic [2:0] PW_16 = 3'd1;
   localparam logic [2:0] PW_8  = 3'd2;
   localparam logic [2:0] PW_4  = 3'd3;
   localparam logic [2:0] PW_2  = 3'd4;

   // Operation encodings: bit1 selects rotate, bit0 selects right.
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_ROL = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   // Decoded request as presented to the shifter.
   typedef struct packed {
      logic [31:0] crs1;
      logic [4:0]  shamt;
      logic [4:0]  pw;       // one-hot: bit0=32 ... bit4=2
      logic        shift;
      logic        rotate;
      logic        left;
      logic        right;
      logic        illegal;
   } sh_req_t;

   localparam int SH_REQ_W = $bits(sh_req_t);

   // Shift-amount mask for a given pack width; zero for illegal encodings.
   function automatic logic [4:0] lane_mask(input logic [2:0] pw);
      logic [4:0] m;
      m = 5'b00000;
      case (pw)
         PW_32:   m = 5'b11111;
         PW_16:   m = 5'b01111;
         PW_8:    m = 5'b00111;
         PW_4:    m = 5'b00011;
         PW_2:    m = 5'b00001;
         default: m = 5'b00000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/p_shfrot_skid.sv
// Generic 2-entry skid buffer. Slot M drives the output, slot S absorbs one
// extra beat so that in_ready_o is a flop (no comb path from out_ready_i).
//
// Handshake: a beat transfers on a side when its valid and ready are both
// high at the clock edge; a valid beat's data is held stable until taken.
module p_shfrot_skid #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         m_valid_q, m_valid_d;
   logic [W-1:0] m_data_q,  m_data_d;
   logic         s_valid_q, s_valid_d;
   logic [W-1:0] s_data_q,  s_data_d;
   logic         push;
   logic         pop;

   assign in_ready_o  = ~s_valid_q;
   assign out_valid_o = m_valid_q;
   assign out_data_o  = m_data_q;

   assign push = in_valid_i & ~s_valid_q;
   assign pop  = m_valid_q & out_ready_i;

   // Next-state for both slots: S drains into M first, otherwise new data
   // lands in M when it is free or leaving, else in S.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (s_valid_q) begin
         if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
         end
      end else if (!m_valid_q || pop) begin
         m_valid_d = push;
         if (push) begin
            m_data_d = in_data_i;
         end
      end else if (push) begin
         s_valid_d = 1'b1;
         s_data_d  = in_data_i;
      end
   end

   // Slot registers; reset clears both slots and their payload at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
      end
   end

endmodule

// File: rtl/p_shfrot_issue.sv
// Issue stage for the packed shift/rotate datapath. Decodes pack width and
// op into one-hot/strobe form, lane-masks the shift amount, and presents the
// result from flops through a 2-entry skid buffer.
// Optional build macro: P_SHFROT_ISSUE_COUNTERS_EN adds cnt_ops/cnt_stall.
//
// Handshake: req_* transfers when req_valid && req_ready at g_clk rise;
// sh_* transfers when sh_valid && sh_ready; payload is stable while stalled.
module p_shfrot_issue
   import p_shfrot_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [4:0]       req_imm,
   input  logic             req_use_imm,
   input  logic [2:0]       req_pw,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic             sh_valid,
   input  logic             sh_ready,
   output logic [31:0]      sh_crs1,
   output logic [4:0]       sh_shamt,
   output logic [4:0]       sh_pw,
   output logic             sh_shift,
   output logic             sh_rotate,
   output logic             sh_left,
   output logic             sh_right,
   output logic [TAG_W-1:0] sh_tag,
   output logic             sh_illegal
`ifdef P_SHFROT_ISSUE_COUNTERS_EN
   ,
   output logic [31:0]      cnt_ops,
   output logic [31:0]      cnt_stall
`endif
);

   localparam int PAY_W = SH_REQ_W + TAG_W;

   sh_req_t          dec;
   sh_req_t          out_req;
   logic [4:0]       shamt_raw;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] out_pay;
   logic             unused_rs2_hi;

   // Upper shift-register bits are architecturally ignored.
   assign unused_rs2_hi = ^req_rs2[31:5];

   // Decode the raw request; illegal widths pass the operand through with
   // every control field cleared so the shifter is a no-op.
   always_comb begin
      dec       = '0;
      shamt_raw = req_use_imm ? req_imm : req_rs2[4:0];
      dec.crs1  = req_rs1;
      case (req_pw)
         PW_32, PW_16, PW_8, PW_4, PW_2: begin
            dec.pw    = 5'b00001 << req_pw;
            dec.shamt = shamt_raw & lane_mask(req_pw);
            case (req_op)
               OP_SLL: begin dec.shift  = 1'b1; dec.left  = 1'b1; end
               OP_SRL: begin dec.shift  = 1'b1; dec.right = 1'b1; end
               OP_ROL: begin dec.rotate = 1'b1; dec.left  = 1'b1; end
               OP_ROR: begin dec.rotate = 1'b1; dec.right = 1'b1; end
               default: ;
            endcase
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   assign in_pay = {req_tag, dec};

   p_shfrot_skid #(
      .W (PAY_W)
   ) u_skid (
      .clk_i       (g_clk),
      .rst_ni      (g_resetn),
      .in_valid_i  (req_valid),
      .in_ready_o  (req_ready),
      .in_data_i   (in_pay),
      .out_valid_o (sh_valid),
      .out_ready_i (sh_ready),
      .out_data_o  (out_pay)
   );

   assign out_req    = out_pay[SH_REQ_W-1:0];
   assign sh_tag     = out_pay[PAY_W-1:SH_REQ_W];
   assign sh_crs1    = out_req.crs1;
   assign sh_shamt   = out_req.shamt;
   assign sh_pw      = out_req.pw;
   assign sh_shift   = out_req.shift;
   assign sh_rotate  = out_req.rotate;
   assign sh_left    = out_req.left;
   assign sh_right   = out_req.right;
   assign sh_illegal = out_req.illegal;

`ifdef P_SHFROT_ISSUE_COUNTERS_EN
   logic [31:0] cnt_ops_q,   cnt_ops_d;
   logic [31:0] cnt_stall_q, cnt_stall_d;

   // Count completed pops and stalled output cycles; both wrap naturally.
   always_comb begin
      cnt_ops_d   = cnt_ops_q;
      cnt_stall_d = cnt_stall_q;
      if (sh_valid && sh_ready) begin
         cnt_ops_d = cnt_ops_q + 32'd1;
      end
      if (sh_valid && !sh_ready) begin
         cnt_stall_d = cnt_stall_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         cnt_ops_q   <= 32'd0;
         cnt_stall_q <= 32'd0;
      end else begin
         cnt_ops_q   <= cnt_ops_d;
         cnt_stall_q <= cnt_stall_d;
      end
   end

   assign cnt_ops   = cnt_ops_q;
   assign cnt_stall = cnt_stall_q;
`endif

endmodule
